// File: rtl/lpc_capture_fifo.sv
// Capture FIFO on a dual-port RAM with registered read port; first-word-fall-through output, 1 edge write-to-valid beyond the write edge.
// Writer has no backpressure: writes into a full FIFO are dropped and counted; reader uses rd_valid/rd_ready.
module lpc_capture_fifo #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int AFULL_LEVEL = 2**AW - 4,
  parameter int OVF_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [DW-1:0]    wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [DW-1:0]    rd_data,
  output logic [AW:0]      level,
  output logic             almost_full,
  output logic             overflow,
  output logic [OVF_W-1:0] overflow_count,
  input  logic             clear_overflow
);

  localparam logic [AW:0] AFULL_THR = (AW+1)'(AFULL_LEVEL);

  logic [DW-1:0] mem [2**AW];

  logic [AW:0] wptr, rptr;
  logic [AW:0] wptr_nxt, rptr_nxt, level_nxt;
  logic        rd_valid_nxt;
  logic        ram_empty, ram_full, rd_issue, wr_accept, wr_drop;

  always_comb begin
    ram_empty    = (wptr == rptr);
    ram_full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    rd_issue     = !ram_empty && (!rd_valid || rd_ready);
    // A full RAM still accepts when the head moves out on this edge.
    wr_accept    = wr_en && (!ram_full || rd_issue);
    wr_drop      = wr_en && !wr_accept && !flush;
    wptr_nxt     = wptr;
    rptr_nxt     = rptr;
    rd_valid_nxt = rd_valid;
    if (flush) begin
      wptr_nxt     = '0;
      rptr_nxt     = '0;
      rd_valid_nxt = 1'b0;
    end else begin
      if (wr_accept) wptr_nxt = wptr + (AW+1)'(1);
      if (rd_issue) begin
        rptr_nxt     = rptr + (AW+1)'(1);
        rd_valid_nxt = 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid_nxt = 1'b0;
      end
    end
    level_nxt = (wptr_nxt - rptr_nxt) + {{AW{1'b0}}, rd_valid_nxt};
  end

  always_ff @(posedge clock) begin
    if (wr_accept && !flush) mem[wptr[AW-1:0]] <= wr_data;
  end

  // Same-address read/write returns the old word, which is the correct head when full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_issue && !flush) begin
      rd_data <= mem[rptr[AW-1:0]];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      rd_valid    <= 1'b0;
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      wptr        <= wptr_nxt;
      rptr        <= rptr_nxt;
      rd_valid    <= rd_valid_nxt;
      level       <= level_nxt;
      almost_full <= (level_nxt >= AFULL_THR);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
    end else if (clear_overflow) begin
      overflow       <= wr_drop;
      overflow_count <= wr_drop ? OVF_W'(1) : '0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
      if (!(&overflow_count)) overflow_count <= overflow_count + OVF_W'(1);
    end
  end

endmodule

// File: doc/lpc_capture_fifo.md
Name: lpc_capture_fifo

Overview:
- Parametrised FIFO for captured sniffer words, built on a dual-port RAM with a registered read port.
- Adds what a bare dual-port RAM lacks: read/write pointer management, first-word-fall-through valid/ready output, fill level, almost-full flag, synchronous flush, and drop accounting on overflow.
- Sits between the LPC/TPM decode logic (writer, no backpressure) and the UART/USB drain logic (reader, valid/ready).

Parameters:
AW, 8, RAM address width; RAM depth = 2**AW.
DW, 8, data word width.
AFULL_LEVEL, 2**AW-4, almost_full asserts when level >= AFULL_LEVEL.
OVF_W, 16, width of the saturating drop counter.

Ports:
clock  in  1  single clock; all logic on posedge.
reset_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous empty; clears stored data.
wr_en  in  1  write strobe from the capture logic; no backpressure.
wr_data  in  DW  word to store.
rd_valid  out  1  rd_data holds a valid word.
rd_ready  in  1  consumer takes rd_data when rd_valid && rd_ready.
rd_data  out  DW  head word, RAM registered output.
level  out  AW+1  words held: RAM occupancy + rd_valid; range 0..2**AW+1.
almost_full  out  1  registered, level >= AFULL_LEVEL.
overflow  out  1  sticky, set on any dropped write.
overflow_count  out  OVF_W  dropped writes, saturating at all-ones.
clear_overflow  in  1  synchronous clear of overflow and overflow_count.

Behaviour:
- Reset (reset_n low, async): wptr=rptr=0, rd_valid=0, rd_data=0, level=0, almost_full=0, overflow=0, overflow_count=0.
- Pointers: AW+1 bits each, MSB is the wrap bit.
  - ram_empty = (wptr == rptr).
  - ram_full = (wptr[AW-1:0] == rptr[AW-1:0]) && (wrap bits differ).
- rd_issue = !ram_empty && (!rd_valid || rd_ready).
  - On rd_issue, the RAM output register loads ram[rptr], rptr increments, and rd_valid becomes 1 at the same edge.
  - Without rd_issue, rd_valid && rd_ready clears rd_valid.
  - rd_data holds its value while no read is issued.
- Write accept = wr_en && (!ram_full || rd_issue).
  - On accept: ram[wptr] <= wr_data and wptr increments.
  - A same-edge read of the same address returns the old contents; this only occurs when full with rd_issue, where the old word is the correct head.
- Latency: a word written at edge N (FIFO otherwise empty) has rd_valid=1 after edge N+1. Sustained throughput is 1 word/cycle in and out with no bubbles.
- Total capacity is 2**AW+1 words (2**AW in RAM plus one in the output register).
- Drop: wr_en && !accept.
  - The word is discarded and overflow is set.
  - overflow_count increments, saturating at 2**OVF_W-1 (holds there, no wrap).
- clear_overflow clears overflow and overflow_count. If a drop happens in the same cycle, the result is overflow=1 and count=1.
- flush (priority over wr_en and rd_issue):
  - Next edge: wptr=rptr=0, rd_valid=0; rd_data is left unchanged.
  - A write in the flush cycle is neither stored nor counted as a drop.
  - overflow and overflow_count are unaffected by flush.
- level and almost_full are registered and reflect post-edge state; they update on the same edge as the pointers.
- Pointer wrap is natural modulo 2**(AW+1); no special handling is required.
- Reset asserted mid-transfer discards all contents immediately. The first write after release behaves as if written to an empty FIFO.

Test Plan (AW=4, DW=8, AFULL_LEVEL=12, OVF_W=4 unless noted):
- Write 0x11 once, rd_ready=0 -> rd_valid=1 and rd_data=0x11 one edge after the write edge; level=1; holds until rd_ready=1, then rd_valid=0 and level=0.
- Write 0x00..0x10 (17 words) with rd_ready=0, then 3 more writes -> level=17; almost_full=1 from the 12th word on; overflow=1, overflow_count=3; reading drains 0x00..0x10 in order.
- FIFO full (17 words), wr_en=1 and rd_ready=1 for 20 cycles with incrementing data -> no drops, level stays 17, read stream is contiguous across the RAM wrap (rptr passes 0x1F->0x00).
- Write 20 words into a full FIFO -> overflow_count saturates at 15; then clear_overflow concurrent with one more drop -> overflow=1, count=1.
- Fill 5 words, assert flush together with wr_en -> next edge level=0, rd_valid=0, overflow unchanged; the next write appears at rd_data after 1 edge.
- Assert reset_n low asynchronously mid-stream (between edges) -> rd_valid, level, and overflow drop to 0 immediately without waiting for a clock edge.
